// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, functs, ALU control and the fixed boot program for the single-cycle CPU.
package cpu_pkg;
    localparam int WIDTH = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctl_e;

    function automatic logic [WIDTH-1:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [WIDTH-1:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [WIDTH-1:0] rom_word(input int idx);
        case (idx)
            0:       rom_word = i_ins(OP_ADDI, 5'd0, 5'd1, 16'd5);
            1:       rom_word = i_ins(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
            2:       rom_word = r_ins(5'd1, 5'd2, 5'd3, FN_ADD);
            3:       rom_word = r_ins(5'd1, 5'd2, 5'd4, FN_SUB);
            4:       rom_word = r_ins(5'd1, 5'd2, 5'd5, FN_AND);
            5:       rom_word = r_ins(5'd1, 5'd2, 5'd6, FN_OR);
            6:       rom_word = r_ins(5'd2, 5'd1, 5'd7, FN_SLT);
            7:       rom_word = i_ins(OP_SW, 5'd0, 5'd3, 16'd4);
            8:       rom_word = i_ins(OP_LW, 5'd0, 5'd8, 16'd4);
            9:       rom_word = i_ins(OP_BEQ, 5'd8, 5'd3, 16'd1);
            10:      rom_word = i_ins(OP_ADDI, 5'd0, 5'd9, 16'd99);
            11:      rom_word = i_ins(OP_ADDI, 5'd0, 5'd9, 16'd7);
            12:      rom_word = {OP_J, 26'd12};
            default: rom_word = '0;
        endcase
    endfunction
endpackage

// File: rtl/regfile.sv
// regfile: 32x32 register file, two async read ports, one sync write port, $0 hardwired to zero.
module regfile
    import cpu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [4:0]       ra1_i,
    input  logic [4:0]       ra2_i,
    input  logic [4:0]       wa_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic [WIDTH-1:0] rd1_o,
    output logic [WIDTH-1:0] rd2_o
);
    logic [WIDTH-1:0] regs_q [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            regs_q <= '{default: '0};
        else if (we_i && wa_i != 5'd0)
            regs_q[wa_i] <= wd_i;
    end

    assign rd1_o = ra1_i == 5'd0 ? '0 : regs_q[ra1_i];
    assign rd2_o = ra2_i == 5'd0 ? '0 : regs_q[ra2_i];
endmodule

// File: rtl/single_cycle_processor.sv
// single_cycle_processor: MIPS-subset single-cycle CPU with internal ROM/RAM, exposing write-back WD3.
// Define BNE_EN to decode opcode 0x05 as bne; otherwise it is an unsupported nop.
module single_cycle_processor
    import cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic               CLK,
    input  logic               RST,
    output logic signed [31:0] WD3
);
`ifdef BNE_EN
    localparam logic BNE_ON = 1'b1;
`else
    localparam logic BNE_ON = 1'b0;
`endif
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d, pc_plus4, instr, imm_ext, rd1, rd2, src_b, alu_y, ram_rd;
    logic [WIDTH-1:0] dmem_q [DMEM_DEPTH];
    logic [5:0]       opcode, funct;
    logic [4:0]       wa;
    logic [DAW-1:0]   daddr;
    logic             is_r, r_ok, is_lw, is_sw, is_beq, is_bne, is_addi, is_j;
    logic             alu_ok, reg_write, take, unused_shamt;
    alu_ctl_e         alu_ctl;

    assign instr = rom_word(int'(pc_q[7:2]) % IMEM_DEPTH);

    always_comb begin
        opcode       = instr[31:26];
        funct        = instr[5:0];
        is_r         = opcode == OP_RTYPE;
        r_ok         = is_r && (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                                funct == FN_OR || funct == FN_SLT);
        is_lw        = opcode == OP_LW;
        is_sw        = opcode == OP_SW;
        is_beq       = opcode == OP_BEQ;
        is_bne       = BNE_ON && opcode == OP_BNE;
        is_addi      = opcode == OP_ADDI;
        is_j         = opcode == OP_J;
        alu_ok       = r_ok || is_lw || is_sw || is_beq || is_bne || is_addi;
        reg_write    = r_ok || is_lw || is_addi;
        wa           = is_r ? instr[15:11] : instr[20:16];
        imm_ext      = {{16{instr[15]}}, instr[15:0]};
        unused_shamt = ^instr[10:6];
        alu_ctl      = !is_r ? ((is_beq || is_bne) ? ALU_SUB : ALU_ADD)
                     : funct == FN_SUB ? ALU_SUB
                     : funct == FN_AND ? ALU_AND
                     : funct == FN_OR  ? ALU_OR
                     : funct == FN_SLT ? ALU_SLT
                     : ALU_ADD;
    end

    regfile u_rf (
        .clk_i (CLK),
        .rst_ni(RST),
        .we_i  (reg_write),
        .ra1_i (instr[25:21]),
        .ra2_i (instr[20:16]),
        .wa_i  (wa),
        .wd_i  (WD3),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    // Branch compare reuses the ALU subtract, so beq/bne expose rs-rt on WD3.
    always_comb begin
        src_b    = (is_r || is_beq || is_bne) ? rd2 : imm_ext;
        alu_y    = alu_ctl == ALU_SUB ? rd1 - src_b
                 : alu_ctl == ALU_AND ? rd1 & src_b
                 : alu_ctl == ALU_OR  ? rd1 | src_b
                 : alu_ctl == ALU_SLT ? {31'd0, $signed(rd1) < $signed(src_b)}
                 : rd1 + src_b;
        daddr    = DAW'(int'(alu_y[7:2]) % DMEM_DEPTH);
        ram_rd   = dmem_q[daddr];
        WD3      = is_lw ? ram_rd : alu_ok ? alu_y : '0;
        pc_plus4 = pc_q + 32'd4;
        take     = (is_beq && rd1 == rd2) || (is_bne && rd1 != rd2);
        pc_d     = is_j ? {pc_plus4[31:28], instr[25:0], 2'b00}
                 : take ? pc_plus4 + {imm_ext[29:0], 2'b00}
                 : pc_plus4;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

    always_ff @(posedge CLK) begin
        if (is_sw)
            dmem_q[daddr] <= rd2;
    end
endmodule

// File: tb/tb_single_cycle_processor.sv
// tb_single_cycle_processor: directed program walk, async-reset cases and random-reset run against an ISA model.
module tb_single_cycle_processor;
    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic signed [31:0] WD3;

    single_cycle_processor dut (
        .CLK(CLK),
        .RST(RST),
        .WD3(WD3)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] wd3;
        int          ridx;
        logic [31:0] rval;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] exp_regs [32];

    // Instruction-set model: program words, architectural state and an interpreter.
    logic [31:0] prog  [64];
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [64];
    logic [31:0] m_pc;

    task automatic m_reset();
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
    endtask

    task automatic model(output logic [31:0] wd, input bit commit);
        logic [31:0] ins, a, b, se, nxt, addr;
        int op, fn, dst;
        bit wr;
        ins  = prog[m_pc[7:2]];
        op   = int'(ins >> 26);
        fn   = int'(ins & 32'h3F);
        a    = m_reg[(ins >> 21) & 31];
        b    = m_reg[(ins >> 16) & 31];
        se   = {{16{ins[15]}}, ins[15:0]};
        addr = a + se;
        dst  = int'((ins >> 16) & 31);
        wd   = 0;
        wr   = 0;
        nxt  = m_pc + 4;
        case (op)
            0: begin
                dst = int'((ins >> 11) & 31);
                wr  = 1;
                case (fn)
                    32:      wd = a + b;
                    34:      wd = a - b;
                    36:      wd = a & b;
                    37:      wd = a | b;
                    42:      wd = ($signed(a) < $signed(b)) ? 1 : 0;
                    default: wr = 0;
                endcase
            end
            35: begin wd = m_mem[addr[7:2]]; wr = 1; end
            43: begin wd = addr; if (commit) m_mem[addr[7:2]] = b; end
            4:  begin wd = a - b; if (a == b) nxt = m_pc + 4 + (se << 2); end
`ifdef BNE_EN
            5:  begin wd = a - b; if (a != b) nxt = m_pc + 4 + (se << 2); end
`endif
            8:  begin wd = addr; wr = 1; end
            2:  nxt = ((m_pc + 4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
            default: ;
        endcase
        if (commit) begin
            if (wr && dst != 0) m_reg[dst] = wd;
            m_pc = nxt;
        end
    endtask

    logic [31:0] wd_m;
    bit          saw99;

    initial begin
        for (int i = 0; i < 64; i++) begin prog[i] = 0; m_mem[i] = 0; end
        prog[0]  = 32'h2001_0005;
        prog[1]  = 32'h2002_FFFD;
        prog[2]  = 32'h0022_1820;
        prog[3]  = 32'h0022_2022;
        prog[4]  = 32'h0022_2824;
        prog[5]  = 32'h0022_3025;
        prog[6]  = 32'h0041_382A;
        prog[7]  = 32'hAC03_0004;
        prog[8]  = 32'h8C08_0004;
        prog[9]  = 32'h1103_0001;
        prog[10] = 32'h2009_0063;
        prog[11] = 32'h2009_0007;
        prog[12] = 32'h0800_000C;

        tbl[0]  = '{32'd0,  32'd5,           1, 32'd5};
        tbl[1]  = '{32'd4,  32'hFFFF_FFFD,   2, 32'hFFFF_FFFD};
        tbl[2]  = '{32'd8,  32'd2,           3, 32'd2};
        tbl[3]  = '{32'd12, 32'd8,           4, 32'd8};
        tbl[4]  = '{32'd16, 32'd5,           5, 32'd5};
        tbl[5]  = '{32'd20, 32'hFFFF_FFFD,   6, 32'hFFFF_FFFD};
        tbl[6]  = '{32'd24, 32'd1,           7, 32'd1};
        tbl[7]  = '{32'd28, 32'd4,           0, 32'd0};
        tbl[8]  = '{32'd32, 32'd2,           8, 32'd2};
        tbl[9]  = '{32'd36, 32'd0,           0, 32'd0};
        tbl[10] = '{32'd44, 32'd7,           9, 32'd7};
        tbl[11] = '{32'd48, 32'd0,           0, 32'd0};

        for (int i = 0; i < 32; i++) exp_regs[i] = 0;
        for (int k = 0; k < 12; k++) if (tbl[k].ridx != 0) exp_regs[tbl[k].ridx] = tbl[k].rval;

        // Reset held for two cycles.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_pc", dut.pc_q, 32'd0);
        chk("rst_wd3", WD3, 32'd5);
        for (int i = 0; i < 32; i++) chk($sformatf("rst_r%0d", i), dut.u_rf.regs_q[i], 32'd0);

        // Program walk w0..w12, w10 skipped by the taken beq.
        RST   = 1'b1;
        saw99 = 0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("pc_%0d", k), dut.pc_q, tbl[k].pc);
            chk($sformatf("wd3_%0d", k), WD3, tbl[k].wd3);
            @(posedge CLK);
            #1;
            if (dut.u_rf.regs_q[9] == 32'd99) saw99 = 1;
            if (tbl[k].ridx != 0)
                chk($sformatf("reg_%0d", tbl[k].ridx), dut.u_rf.regs_q[tbl[k].ridx], tbl[k].rval);
            if (tbl[k].pc == 32'd28) chk("ram1", dut.dmem_q[1], 32'd2);
            @(negedge CLK);
        end
        chk("never99", 32'(saw99), 32'd0);

        // Jump self-loop holds PC and state.
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("jloop_pc_%0d", c), dut.pc_q, 32'd48);
            chk($sformatf("jloop_wd3_%0d", c), WD3, 32'd0);
            @(posedge CLK);
            @(negedge CLK);
        end
        for (int i = 0; i < 32; i++) chk($sformatf("jloop_r%0d", i), dut.u_rf.regs_q[i], exp_regs[i]);

        // Async reset between edges at cycle 5.
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("c5_pc", dut.pc_q, 32'd20);
        #1 RST = 1'b0;
        #1;
        chk("arst_pc", dut.pc_q, 32'd0);
        chk("arst_wd3", WD3, 32'd5);
        for (int i = 1; i < 8; i++) chk($sformatf("arst_r%0d", i), dut.u_rf.regs_q[i], 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rerun_wd3_%0d", k), WD3, tbl[k].wd3);
            @(posedge CLK);
            @(negedge CLK);
        end

        // Random async-reset pulses against the ISA model.
        RST = 1'b0;
        m_reset();
        @(negedge CLK);
        RST = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 24) == 0) begin
                #1 RST = 1'b0;
                m_reset();
                #1 chk("rnd_arst_pc", dut.pc_q, 32'd0);
                #1 RST = 1'b1;
            end
            model(wd_m, 0);
            chk($sformatf("rnd_wd3_%0d", c), WD3, wd_m);
            chk($sformatf("rnd_pc_%0d", c), dut.pc_q, m_pc);
            @(posedge CLK);
            model(wd_m, 1);
            @(negedge CLK);
        end
        for (int i = 0; i < 32; i++) chk($sformatf("rnd_r%0d", i), dut.u_rf.regs_q[i], m_reg[i]);
        chk("rnd_ram1", dut.dmem_q[1], m_mem[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
